// File: rtl/data_distributor_pkg.sv
// Shared types and select-decode helpers for the distributor/selector pair.
// Helpers take selects zero-extended to MAX_SEL_WIDTH so any width up to that can reuse them.
package data_distributor_pkg;

  localparam int MAX_SEL_WIDTH = 32;
  localparam int MAX_IDX_WIDTH = $clog2(MAX_SEL_WIDTH);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic is_onehot(input logic [MAX_SEL_WIDTH-1:0] sel);
    return (sel != '0) && ((sel & (sel - MAX_SEL_WIDTH'(1))) == '0);
  endfunction

  // Index of the set bit; meaningful only when is_onehot(sel) holds.
  function automatic logic [MAX_IDX_WIDTH-1:0] onehot_to_index(input logic [MAX_SEL_WIDTH-1:0] sel);
    logic [MAX_IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_SEL_WIDTH; i++) begin
      if (sel[i]) idx = idx | MAX_IDX_WIDTH'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/data_distributor_slot.sv
// Single-entry output slot: write-enable fill, valid/ready drain, drain+refill in one cycle.
// The write enable is only raised by the top when the slot is empty or being drained.
module data_distributor_slot
  import data_distributor_pkg::*;
#(
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  slot_state_e           r_state;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else if (i_wr_en) begin
      r_state <= SLOT_FULL;
      r_data  <= i_wr_data;
    end else if (i_ready) begin
      r_state <= SLOT_EMPTY;
    end
  end

  assign o_valid = (r_state == SLOT_FULL);
  assign o_data  = r_data;

endmodule

// File: rtl/data_distributor.sv
// Registered 1-to-N scatter stage with one-hot select; illegal selects are consumed,
// flagged with a one-cycle sel_error pulse and counted in a saturating drop counter.
//
// Handshake: a word transfers on a rising edge where data_in_valid && data_in_ready;
// slot k transfers to its consumer on an edge where data_out_valid[k] && data_out_ready[k].
// data_in_ready never looks at data_in_valid.
module data_distributor
  import data_distributor_pkg::*;
#(
  parameter int SEL_WIDTH      = 4,
  parameter int DATA_WIDTH     = 2,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEL_WIDTH-1:0]      sel_in,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      data_in_valid,
  output logic                      data_in_ready,
  output logic [DATA_WIDTH-1:0]     data_out [SEL_WIDTH],
  output logic [SEL_WIDTH-1:0]      data_out_valid,
  input  logic [SEL_WIDTH-1:0]      data_out_ready,
  output logic                      sel_error,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  logic                      w_legal;
  logic                      w_slot_ok;
  logic                      w_drop;
  logic [SEL_WIDTH-1:0]      w_wr_en;
  logic                      r_sel_error;
  logic [DROP_CNT_WIDTH-1:0] r_drop_count;

  assign w_legal = is_onehot(MAX_SEL_WIDTH'(sel_in));
  // With a legal one-hot select, this reduction picks out exactly the selected slot.
  assign w_slot_ok     = |(sel_in & (~data_out_valid | data_out_ready));
  assign data_in_ready = w_legal ? w_slot_ok : 1'b1;
  assign w_drop        = data_in_valid & ~w_legal;
  assign w_wr_en       = (data_in_valid & w_legal & data_in_ready) ? sel_in : '0;

  for (genvar k = 0; k < SEL_WIDTH; k++) begin : g_slot
    data_distributor_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_wr_en  (w_wr_en[k]),
      .i_wr_data(data_in),
      .i_ready  (data_out_ready[k]),
      .o_valid  (data_out_valid[k]),
      .o_data   (data_out[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_error  <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_sel_error <= w_drop;
      if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign sel_error  = r_sel_error;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_data_distributor.sv
// Directed bench for data_distributor: per-cycle comparison against a slot/queue-level
// model plus hand-computed literal expectations at the key points of each scenario.
module tb_data_distributor;

  localparam int SW = 4;
  localparam int DW = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] sel_in = '0;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic [DW-1:0] data_out [SW];
  logic [SW-1:0] data_out_valid;
  logic [SW-1:0] data_out_ready = '0;
  logic          sel_error;
  logic [CW-1:0] drop_count;

  data_distributor #(.SEL_WIDTH(SW), .DATA_WIDTH(DW), .DROP_CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sel_in        (sel_in),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .sel_error     (sel_error),
    .drop_count    (drop_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: slots as arrays, drop counter as a clamped integer
  bit          m_full [SW];
  logic [DW-1:0] m_data [SW];
  int          m_drops = 0;
  bit          m_err   = 1'b0;

  initial for (int k = 0; k < SW; k++) begin m_full[k] = 0; m_data[k] = '0; end

  function automatic int sel_target();
    int n = 0, t = -1;
    for (int k = 0; k < SW; k++) if (sel_in[k]) begin n++; t = k; end
    return (n == 1) ? t : -1;
  endfunction

  function automatic bit model_ready();
    int t = sel_target();
    if (t < 0) return 1'b1;
    return !m_full[t] || data_out_ready[t];
  endfunction

  always @(posedge clk) begin
    int t;
    bit accept;
    if (!rst_n) begin
      for (int k = 0; k < SW; k++) begin m_full[k] = 0; m_data[k] = '0; end
      m_drops = 0;
      m_err   = 0;
    end else begin
      t      = sel_target();
      accept = data_in_valid && model_ready();
      m_err  = data_in_valid && (t < 0);
      if (m_err) m_drops = (m_drops + 1 > 255) ? 255 : m_drops + 1;
      for (int k = 0; k < SW; k++) begin
        if (accept && t == k) begin
          m_full[k] = 1;
          m_data[k] = data_in;
        end else if (data_out_ready[k]) begin
          m_full[k] = 0;
        end
      end
    end
  end

  // compare process, mid-cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < SW; k++) begin
        check($sformatf("cyc_valid[%0d]", k), 32'(data_out_valid[k]), 32'(m_full[k]));
        check($sformatf("cyc_data[%0d]", k), 32'(data_out[k]), 32'(m_data[k]));
      end
      check("cyc_sel_error", 32'(sel_error), 32'(m_err));
      check("cyc_drop_count", 32'(drop_count), 32'(m_drops));
      check("cyc_in_ready", 32'(data_in_ready), 32'(model_ready()));
    end
  end

  // driver tasks
  task automatic set_in(input logic [SW-1:0] s, input logic [DW-1:0] d,
                        input logic v, input logic [SW-1:0] r);
    sel_in = s; data_in = d; data_in_valid = v; data_out_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // reset, then idle
    set_in(4'b0001, 2'd0, 1'b0, 4'b0000);
    tick();
    cmp_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_valid", 32'(data_out_valid), 32'h0);
    check("idle_drop", 32'(drop_count), 32'h0);
    check("idle_ready", 32'(data_in_ready), 32'h1);

    // fill each slot k with value k
    for (int i = 0; i < SW; i++) begin
      set_in(SW'(1 << i), DW'(i), 1'b1, 4'b0000);
      tick();
    end
    check("fill_valid", 32'(data_out_valid), 32'hF);
    for (int k = 0; k < SW; k++) check($sformatf("fill_data[%0d]", k), 32'(data_out[k]), 32'(k));
    set_in(4'b0100, 2'd3, 1'b1, 4'b0000);
    check("full_blocked_ready", 32'(data_in_ready), 32'h0);
    tick();
    check("full_keep_data2", 32'(data_out[2]), 32'h2);

    // drain + refill slot 1
    set_in(4'b0010, 2'd3, 1'b1, 4'b0010);
    check("refill_ready", 32'(data_in_ready), 32'h1);
    tick();
    check("refill_data1", 32'(data_out[1]), 32'h3);
    check("refill_valid", 32'(data_out_valid), 32'hF);

    // illegal selects: zero then multi-hot
    set_in(4'b0000, 2'd1, 1'b1, 4'b0000);
    check("drop0_ready", 32'(data_in_ready), 32'h1);
    tick();
    check("drop0_err", 32'(sel_error), 32'h1);
    set_in(4'b0110, 2'd2, 1'b1, 4'b0000);
    check("drop1_ready", 32'(data_in_ready), 32'h1);
    tick();
    check("drop1_err", 32'(sel_error), 32'h1);
    check("drop1_count", 32'(drop_count), 32'h2);
    check("drop1_data1", 32'(data_out[1]), 32'h3);
    set_in(4'b0000, 2'd0, 1'b0, 4'b0000);
    tick();
    check("idle_err_low", 32'(sel_error), 32'h0);
    check("idle_valid_kept", 32'(data_out_valid), 32'hF);

    // drop while slot 3 drains
    set_in(4'b0000, 2'd0, 1'b1, 4'b1000);
    tick();
    check("drop_drain_err", 32'(sel_error), 32'h1);
    check("drop_drain_valid", 32'(data_out_valid), 32'h7);
    check("drop_drain_count", 32'(drop_count), 32'h3);

    // back-to-back writes to slot 0 with its consumer ready
    for (int i = 1; i <= 3; i++) begin
      set_in(4'b0001, DW'(i), 1'b1, 4'b0001);
      check($sformatf("b2b_ready%0d", i), 32'(data_in_ready), 32'h1);
      tick();
    end
    check("b2b_data0", 32'(data_out[0]), 32'h3);
    set_in(4'b0000, 2'd0, 1'b0, 4'b1111);
    tick();
    check("drain_all_valid", 32'(data_out_valid), 32'h0);

    // saturation of the drop counter
    for (int i = 0; i < 300; i++) begin
      set_in((i % 2 == 0) ? 4'b0000 : 4'b1111, DW'(i), 1'b1, 4'b0000);
      tick();
    end
    check("sat_count", 32'(drop_count), 32'hFF);
    set_in(4'b0000, 2'd0, 1'b0, 4'b0000);
    tick();
    check("sat_err_low", 32'(sel_error), 32'h0);
    check("sat_hold", 32'(drop_count), 32'hFF);

    // reset mid-transfer
    set_in(4'b0001, 2'd2, 1'b1, 4'b0000);
    tick();
    set_in(4'b1000, 2'd1, 1'b1, 4'b0000);
    tick();
    check("prerst_valid", 32'(data_out_valid), 32'h9);
    set_in(4'b0000, 2'd0, 1'b0, 4'b0000);
    rst_n = 1'b0;
    tick();
    check("rst_valid", 32'(data_out_valid), 32'h0);
    check("rst_drop", 32'(drop_count), 32'h0);
    check("rst_err", 32'(sel_error), 32'h0);
    for (int k = 0; k < SW; k++) check($sformatf("rst_data[%0d]", k), 32'(data_out[k]), 32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
